// File: rtl/fp_sincos_sched_pkg.sv
// Shared types and constants for the sin/cos unit scheduler.
package fp_sincos_sched_pkg;

    typedef logic [63:0] fp64_t;

    typedef enum logic [1:0] {
        SS_IDLE  = 2'd0,
        SS_ISSUE = 2'd1,
        SS_WAIT  = 2'd2,
        SS_RESP  = 2'd3
    } sincos_sched_state_t;

    localparam fp64_t FP64_QNAN = 64'h7FF8000000000000;

endpackage

// File: rtl/fp_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module fp_rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            any,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);

    logic [IDW:0] idx;

    always_comb begin
        any   = 1'b0;
        grant = '0;
        id    = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!any && req[idx[IDW-1:0]]) begin
                any                = 1'b1;
                grant[idx[IDW-1:0]] = 1'b1;
                id                 = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_sincos_sched.sv
// Round-robin scheduler sharing one fpSincos64 unit among NREQ requesters.
// Define FP_SINCOS_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT cycles with a NaN/error response.
//
// state | meaning
// IDLE  | waiting for any request; latches winner id, operand and rounding mode
// ISSUE | gnt and su_ld pulse for the latched requester
// WAIT  | unit busy; waiting for su_done (or timeout when enabled)
// RESP  | rsp_valid pulse to the latched requester; advance rr_ptr
module fp_sincos_sched
    import fp_sincos_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  fp64_t [NREQ-1:0]     req_a,
    input  logic [NREQ-1:0][2:0] req_rm,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output fp64_t                rsp_sin,
    output fp64_t                rsp_cos,
    output logic                 rsp_err,
    output logic                 su_ld,
    output fp64_t                su_a,
    output logic [2:0]           su_rm,
    input  fp64_t                su_sin,
    input  fp64_t                su_cos,
    input  logic                 su_done
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE  = SS_IDLE;
    localparam logic [1:0] ISSUE = SS_ISSUE;
    localparam logic [1:0] WAIT  = SS_WAIT;
    localparam logic [1:0] RESP  = SS_RESP;

    logic [1:0]     state;
    logic [IDW-1:0] id;
    logic [IDW-1:0] rr_ptr;

    logic            pick_any;
    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_id;
    fp64_t           sel_a;
    logic [2:0]      sel_rm;

    fp_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .grant  (pick_gnt),
        .id     (pick_id)
    );

    always_comb begin
        sel_a  = '0;
        sel_rm = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_a  = sel_a | req_a[i];
                sel_rm = sel_rm | req_rm[i];
            end
        end
    end

`ifdef FP_SINCOS_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    logic             err_q;

    assign timeout = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            // su_done takes priority over a coincident timeout
            if (su_done) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            id      <= '0;
            rr_ptr  <= '0;
            su_a    <= '0;
            su_rm   <= '0;
            rsp_sin <= '0;
            rsp_cos <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        id    <= pick_id;
                        su_a  <= sel_a;
                        su_rm <= sel_rm;
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (su_done) begin
                        rsp_sin <= su_sin;
                        rsp_cos <= su_cos;
                        state   <= RESP;
                    end
`ifdef FP_SINCOS_SCHED_TIMEOUT_EN
                    else if (timeout) begin
                        rsp_sin <= FP64_QNAN;
                        rsp_cos <= FP64_QNAN;
                        state   <= RESP;
                    end
`endif
                end
                RESP: begin
                    rr_ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // su_a/su_rm are registers that only change in IDLE, so they stay put ISSUE..RESP
    assign su_ld     = (state == ISSUE);
    assign gnt       = (state == ISSUE) ? (NREQ'(1) << id) : '0;
    assign rsp_valid = (state == RESP)  ? (NREQ'(1) << id) : '0;

endmodule

// File: tb/tb_fp_sincos_sched.sv
// Self-checking bench for fp_sincos_sched with a behavioural round-robin model and a scripted sin/cos unit.
module tb_fp_sincos_sched;
    import fp_sincos_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0][63:0] req_a;
    logic [NREQ-1:0][2:0] req_rm;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [63:0]          rsp_sin;
    logic [63:0]          rsp_cos;
    logic                 rsp_err;
    logic                 su_ld;
    logic [63:0]          su_a;
    logic [2:0]           su_rm;
    logic [63:0]          su_sin;
    logic [63:0]          su_cos;
    logic                 su_done;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;
    logic [NREQ-1:0] obs_gnt;

    fp_sincos_sched #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_rm    (req_rm),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_sin   (rsp_sin),
        .rsp_cos   (rsp_cos),
        .rsp_err   (rsp_err),
        .su_ld     (su_ld),
        .su_a      (su_a),
        .su_rm     (su_rm),
        .su_sin    (su_sin),
        .su_cos    (su_cos),
        .su_done   (su_done)
    );

    always #5 clk = ~clk;

    function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic raise(input int i);
        req_a[i]  = rnd64();
        req_rm[i] = 3'($urandom_range(0, 7));
        req[i]    = 1'b1;
    endtask

    // Serves one operation: expects gnt next cycle, unit answers after lat WAIT cycles.
    task automatic serve_one(input int lat, input logic [63:0] s, input logic [63:0] c,
                             input bit stale_issue, input int blip);
        int exp_id;
        bit got;
        int n;
        logic [63:0] a_exp;
        logic [2:0]  rm_exp;
        logic [NREQ-1:0] oh;
        exp_id = model_pick(req, ptr_m);
        if (exp_id < 0) begin
            total++; bad++;
            $display("FAIL serve_setup: no request pending, required at least one");
            return;
        end
        a_exp  = req_a[exp_id];
        rm_exp = req_rm[exp_id];
        oh     = NREQ'(1) << exp_id;
        got = 0; n = 0;
        while (!got && n < 8) begin
            @(posedge clk); #1; n++;
            if (gnt != '0) got = 1;
        end
        total++;
        if (!got || n != 1) begin
            bad++;
            $display("FAIL gnt_latency: got=%0d cycles=%0d, required gnt after 1 cycle", got, n);
            if (!got) return;
        end
        obs_gnt = gnt;
        total++;
        if (gnt !== oh) begin
            bad++; $display("FAIL gnt_id: gnt=%b, required %b", gnt, oh);
        end
        total++;
        if (su_ld !== 1'b1 || su_a !== a_exp || su_rm !== rm_exp) begin
            bad++;
            $display("FAIL issue_bus: su_ld=%b su_a=%h su_rm=%0d, required 1 %h %0d", su_ld, su_a, su_rm, a_exp, rm_exp);
        end
        req[exp_id] = 1'b0;
        if (stale_issue) begin
            su_done = 1'b1; su_sin = ~s; su_cos = ~c;
        end
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            su_done = 1'b0;
            if (blip >= 0 && k == 1) req[blip] = 1'b1;
            if (blip >= 0 && k == 2) req[blip] = 1'b0;
            total++;
            if (gnt !== '0 || su_ld !== 1'b0 || rsp_valid !== '0 || su_rm !== rm_exp || su_a !== a_exp) begin
                bad++;
                $display("FAIL wait_hold k=%0d: gnt=%b su_ld=%b rsp_valid=%b su_rm=%0d su_a=%h, required 0 0 0 %0d %h",
                         k, gnt, su_ld, rsp_valid, su_rm, su_a, rm_exp, a_exp);
            end
            if (k == lat) begin
                su_done = 1'b1; su_sin = s; su_cos = c;
            end
        end
        if (blip >= 0) req[blip] = 1'b0;
        @(posedge clk); #1;
        su_done = 1'b0; su_sin = rnd64(); su_cos = rnd64();
        total++;
        if (rsp_valid !== oh || rsp_sin !== s || rsp_cos !== c || rsp_err !== 1'b0 || su_rm !== rm_exp) begin
            bad++;
            $display("FAIL response: valid=%b sin=%h cos=%h err=%b rm=%0d, required %b %h %h 0 %0d",
                     rsp_valid, rsp_sin, rsp_cos, rsp_err, su_rm, oh, s, c, rm_exp);
        end
        ptr_m = (exp_id + 1) % NREQ;
        @(posedge clk); #1;
        total++;
        if (rsp_valid !== '0 || rsp_sin !== s || rsp_cos !== c) begin
            bad++;
            $display("FAIL result_hold: valid=%b sin=%h cos=%h, required 0 %h %h", rsp_valid, rsp_sin, rsp_cos, s, c);
        end
    endtask

    task automatic idle_quiet(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            su_done = 1'b0;
            total++;
            if (gnt !== '0 || rsp_valid !== '0) begin
                bad++; $display("FAIL %s: gnt=%b rsp_valid=%b, required 0 0", tag, gnt, rsp_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_a = '0; req_rm = '0;
        su_done = 1'b0; su_sin = '0; su_cos = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({gnt, rsp_valid, su_ld, rsp_err, su_rm} !== '0) begin
            bad++; $display("FAIL reset_ctrl: gnt=%b valid=%b ld=%b err=%b rm=%0d, required all 0",
                            gnt, rsp_valid, su_ld, rsp_err, su_rm);
        end
        total++;
        if ({su_a, rsp_sin, rsp_cos} !== '0) begin
            bad++; $display("FAIL reset_data: su_a=%h sin=%h cos=%h, required 0", su_a, rsp_sin, rsp_cos);
        end
        rst = 1'b0;
        ptr_m = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        req_a[2] = 64'h3FF0000000000000; req_rm[2] = 3'd0; req[2] = 1'b1;
        serve_one(5, 64'h3FEAED548F090CEE, 64'h3FE14A280FB5068C, 1'b0, -1);
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        test_reset();
        for (int i = 0; i < NREQ; i++) raise(i);
        for (int j = 0; j < 5; j++) begin
            serve_one($urandom_range(1, 6), rnd64(), rnd64(), 1'b0, -1);
            total++;
            if (obs_gnt !== (NREQ'(1) << order[j])) begin
                bad++; $display("FAIL rr_order op%0d: gnt=%b, required %b", j, obs_gnt, NREQ'(1) << order[j]);
            end
            for (int i = 0; i < NREQ; i++) if (!req[i]) raise(i);
        end
        req = '0;
    endtask

    task automatic test_stale_done();
        su_done = 1'b1; su_sin = rnd64(); su_cos = rnd64();
        idle_quiet(3, "stale_idle");
        raise(0);
        serve_one(3, rnd64(), rnd64(), 1'b1, -1);
    endtask

    task automatic test_withdraw();
        raise(3);
        serve_one(4, rnd64(), rnd64(), 1'b0, 1);
        idle_quiet(6, "withdraw");
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < NREQ; i++) if (!req[i] && $urandom_range(0, 1) == 1) raise(i);
            if (req == '0) raise($urandom_range(0, NREQ - 1));
            serve_one($urandom_range(1, 6), rnd64(), rnd64(), 1'b0, -1);
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        bit got;
        raise(1);
        serve_one(2, rnd64(), rnd64(), 1'b0, -1);
        raise(2);
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clk); #1;
            if (gnt != '0) got = 1;
        end
        total++;
        if (gnt !== 4'b0100) begin
            bad++; $display("FAIL mid_gnt: gnt=%b, required 0100", gnt);
        end
        req = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({gnt, rsp_valid, su_ld, rsp_err, su_rm, su_a, rsp_sin, rsp_cos} !== '0) begin
            bad++; $display("FAIL mid_reset_outputs: gnt=%b valid=%b ld=%b su_a=%h sin=%h, required all 0",
                            gnt, rsp_valid, su_ld, su_a, rsp_sin);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        su_done = 1'b1; su_sin = rnd64(); su_cos = rnd64();
        idle_quiet(3, "late_done");
        ptr_m = 0;
        raise(0); raise(3);
        serve_one(2, rnd64(), rnd64(), 1'b0, -1);
        req = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
`ifdef FP_SINCOS_SCHED_TIMEOUT_EN
        bit got;
        int n;
        raise(1);
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clk); #1;
            if (gnt != '0) got = 1;
        end
        total++;
        if (gnt !== 4'b0010) begin
            bad++; $display("FAIL tmo_gnt: gnt=%b, required 0010", gnt);
        end
        req = '0;
        got = 0; n = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (rsp_valid != '0) got = 1;
        end
        total++;
        if (n != TMO + 1 || rsp_valid !== 4'b0010) begin
            bad++; $display("FAIL tmo_latency: cycles=%0d valid=%b, required %0d 0010", n, rsp_valid, TMO + 1);
        end
        total++;
        if (rsp_err !== 1'b1 || rsp_sin !== FP64_QNAN || rsp_cos !== FP64_QNAN) begin
            bad++; $display("FAIL tmo_result: err=%b sin=%h cos=%h, required 1 %h %h", rsp_err, rsp_sin, rsp_cos,
                            FP64_QNAN, FP64_QNAN);
        end
        ptr_m = 2;
        @(posedge clk); #1;
`else
        raise(1);
        serve_one(1000, rnd64(), rnd64(), 1'b0, -1);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stale_done();
        test_withdraw();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
